imm_ext_arbiter: RTL and testbench

//  Shares one immediate sign/zero-extend unit (16->32, fixed latency EXT_DELAY) among N_REQ requesters
//  (decode, branch-target, load/store address gen). Per-requester valid/ready intake, round-robin grant,

---
 rtl/imm_ext_pkg.sv | 42 ++++
 rtl/imm_ext_arbiter_rr.sv | 53 +++++
 rtl/imm_ext_arbiter.sv | 129 ++++++++++++
 tb/tb_imm_ext_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// ============================================================================
//  Module : imm_ext_pkg
//  Shared opcode constants and extend-mode decode for imm_ext_arbiter.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package imm_ext_pkg;

   localparam logic [5:0] OP_LUI  = 6'h0F;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_XORI = 6'h0E;

   typedef struct packed {
      logic is_signed;
      logic load_upper;
   } ext_mode_t;

   // Logical immediates zero-extend, LUI shifts up, everything else sign-extends.
   function automatic ext_mode_t ext_mode(input logic [5:0] opcode);
      ext_mode_t m;
      m.is_signed  = 1'b1;
      m.load_upper = 1'b0;
      case (opcode)
         OP_LUI: begin
            m.is_signed  = 1'b0;
            m.load_upper = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI: m.is_signed = 1'b0;
         default: ;
      endcase
      return m;
   endfunction

   function automatic int idw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/imm_ext_arbiter_rr.sv
// ============================================================================
//  Module : rr_arbiter
//  Round-robin grant over a request vector, searching upward from a pointer.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
   import imm_ext_pkg::*;
#(
   parameter  int N   = 4,
   localparam int IDW = idw_of(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   i_req,
   input  logic           i_advance,
   output logic [N-1:0]   o_grant,
   output logic [IDW-1:0] o_idx
);

   logic [IDW-1:0] r_ptr;
   logic [IDW:0]   w_cand;
   logic           w_found;

   // One extra bit on the candidate lets the wrap be a single subtract.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_cand  = '0;
      for (int i = 0; i < N; i++) begin
         w_cand = {1'b0, r_ptr} + (IDW+1)'(i);
         if (w_cand >= (IDW+1)'(N))
            w_cand = w_cand - (IDW+1)'(N);
         if (!w_found && i_req[w_cand[IDW-1:0]]) begin
            w_found                   = 1'b1;
            o_grant[w_cand[IDW-1:0]]  = 1'b1;
            o_idx                     = w_cand[IDW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ptr <= '0;
      else if (i_advance)
         r_ptr <= (o_idx == IDW'(N-1)) ? '0 : o_idx + 1'b1;
   end

endmodule

`default_nettype wire

// File: rtl/imm_ext_arbiter.sv
// ============================================================================
//  Module : imm_ext_arbiter
//  Shares one external immediate extender among N_REQ requesters with tagged return.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_ext_arbiter
   import imm_ext_pkg::*;
#(
   parameter  int N_REQ     = 4,
   parameter  int IN_W      = 16,
   parameter  int OUT_W     = 32,
   parameter  int OP_W      = 6,
   parameter  int EXT_DELAY = 0,
   localparam int IDW       = idw_of(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_flush,
   input  logic [N_REQ-1:0]     i_req_valid,
   output logic [N_REQ-1:0]     o_req_ready,
   input  logic [OP_W*N_REQ-1:0] i_req_opcode,
   input  logic [IN_W*N_REQ-1:0] i_req_imm,
   output logic                 o_ext_is_signed,
   output logic                 o_ext_load_upper,
   output logic [IN_W-1:0]      o_ext_data_in,
   input  logic [OUT_W-1:0]     i_ext_data_out,
   output logic                 o_rsp_valid,
   output logic [IDW-1:0]       o_rsp_id,
   output logic [OUT_W-1:0]     o_rsp_data
);

   typedef struct packed {
      logic           v;
      logic [IDW-1:0] id;
   } tag_t;

   logic [N_REQ-1:0] w_elig;
   logic [N_REQ-1:0] w_grant;
   logic [N_REQ-1:0] r_busy;
   logic [IDW-1:0]   w_idx;
   logic             w_accept;
   logic [OP_W-1:0]  w_sel_op;
   logic [IN_W-1:0]  w_sel_imm;
   ext_mode_t        w_mode;
   logic             r_ext_signed;
   logic             r_ext_upper;
   logic [IN_W-1:0]  r_ext_data;
   tag_t             r_tag [EXT_DELAY:0];
   tag_t             w_last;

   assign w_elig = i_req_valid & ~r_busy;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (w_elig),
      .i_advance (w_accept),
      .o_grant   (w_grant),
      .o_idx     (w_idx)
   );

   // Ready is also held low while reset is asserted so nothing is offered then.
   assign o_req_ready = w_grant & ~r_busy & {N_REQ{~i_flush & rst_n}};
   assign w_accept    = |(o_req_ready & i_req_valid);

   always_comb begin
      w_sel_op  = '0;
      w_sel_imm = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_grant[k]) begin
            w_sel_op  = i_req_opcode[OP_W*k +: OP_W];
            w_sel_imm = i_req_imm[IN_W*k +: IN_W];
         end
      end
   end

   assign w_mode = ext_mode(w_sel_op[5:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ext_signed <= 1'b0;
         r_ext_upper  <= 1'b0;
         r_ext_data   <= '0;
      end else if (w_accept) begin
         r_ext_signed <= w_mode.is_signed;
         r_ext_upper  <= w_mode.load_upper;
         r_ext_data   <= w_sel_imm;
      end
   end

   assign o_ext_is_signed  = r_ext_signed;
   assign o_ext_load_upper = r_ext_upper;
   assign o_ext_data_in    = r_ext_data;

   assign w_last      = r_tag[EXT_DELAY];
   assign o_rsp_valid = w_last.v & ~i_flush;
   assign o_rsp_id    = w_last.id;
   assign o_rsp_data  = o_rsp_valid ? i_ext_data_out : '0;

   // Tag stages track the extender's internal registers one-for-one, plus the input register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s <= EXT_DELAY; s++)
            r_tag[s] <= '0;
         r_busy <= '0;
      end else begin
         r_tag[0].v <= w_accept;
         if (w_accept)
            r_tag[0].id <= w_idx;
         for (int s = 1; s <= EXT_DELAY; s++) begin
            r_tag[s].v  <= r_tag[s-1].v & ~i_flush;
            r_tag[s].id <= r_tag[s-1].id;
         end
         for (int k = 0; k < N_REQ; k++) begin
            if (i_flush)
               r_busy[k] <= 1'b0;
            else if (w_accept && w_grant[k])
               r_busy[k] <= 1'b1;
            else if (o_rsp_valid && (o_rsp_id == IDW'(k)))
               r_busy[k] <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imm_ext_arbiter.sv
// ============================================================================
//  Module : tb_imm_ext_arbiter
//  Directed bench: one DUT with a combinational extender, one with a 2-stage extender.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imm_ext_arbiter;

   localparam int N   = 4;
   localparam int IW  = 16;
   localparam int OW  = 32;
   localparam int OPW = 6;
   localparam int IDW = 2;

   logic clk, rst_n, flush;
   logic [N-1:0]     a_valid, a_ready, b_valid, b_ready;
   logic [OPW*N-1:0] a_op, b_op;
   logic [IW*N-1:0]  a_imm, b_imm;
   logic             a_es, a_eu, b_es, b_eu;
   logic [IW-1:0]    a_din, b_din;
   logic [OW-1:0]    a_dout, b_dout, b_p1, b_p2;
   logic             a_rv, b_rv;
   logic [IDW-1:0]   a_rid, b_rid;
   logic [OW-1:0]    a_rd, b_rd;

   int vectors = 0;
   int errors  = 0;

   imm_ext_arbiter #(.N_REQ(N), .IN_W(IW), .OUT_W(OW), .OP_W(OPW), .EXT_DELAY(0)) u_a (
      .clk(clk), .rst_n(rst_n), .i_flush(flush),
      .i_req_valid(a_valid), .o_req_ready(a_ready), .i_req_opcode(a_op), .i_req_imm(a_imm),
      .o_ext_is_signed(a_es), .o_ext_load_upper(a_eu), .o_ext_data_in(a_din),
      .i_ext_data_out(a_dout), .o_rsp_valid(a_rv), .o_rsp_id(a_rid), .o_rsp_data(a_rd)
   );

   imm_ext_arbiter #(.N_REQ(N), .IN_W(IW), .OUT_W(OW), .OP_W(OPW), .EXT_DELAY(2)) u_b (
      .clk(clk), .rst_n(rst_n), .i_flush(flush),
      .i_req_valid(b_valid), .o_req_ready(b_ready), .i_req_opcode(b_op), .i_req_imm(b_imm),
      .o_ext_is_signed(b_es), .o_ext_load_upper(b_eu), .o_ext_data_in(b_din),
      .i_ext_data_out(b_dout), .o_rsp_valid(b_rv), .o_rsp_id(b_rid), .o_rsp_data(b_rd)
   );

   function automatic logic [OW-1:0] ext_f(input logic s, input logic u, input logic [IW-1:0] d);
      if (u)      return {d, 16'h0000};
      else if (s) return {{16{d[15]}}, d};
      else        return {16'h0000, d};
   endfunction

   assign a_dout = ext_f(a_es, a_eu, a_din);
   assign b_dout = b_p2;

   initial begin
      b_p1 = '0;
      b_p2 = '0;
   end

   always @(posedge clk) begin
      b_p1 <= ext_f(b_es, b_eu, b_din);
      b_p2 <= b_p1;
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic set_a(input int k, input logic [5:0] op, input logic [15:0] imm);
      a_valid[k]        = 1'b1;
      a_op[OPW*k +: OPW] = op;
      a_imm[IW*k +: IW]  = imm;
   endtask

   task automatic set_b(input int k, input logic [5:0] op, input logic [15:0] imm);
      b_valid[k]        = 1'b1;
      b_op[OPW*k +: OPW] = op;
      b_imm[IW*k +: IW]  = imm;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0;
      a_valid = '0; b_valid = '0; a_op = '0; b_op = '0; a_imm = '0; b_imm = '0;
      cyc(); cyc();
      vectors++;
      if ({a_ready, a_rv, a_rid, a_es, a_eu, a_din} !== '0) begin
         errors++;
         $display("FAIL reset_idle: got %h expected 0", {a_ready, a_rv, a_rid, a_es, a_eu, a_din});
      end
      rst_n = 1'b1;
      cyc();
      set_b(0, 6'h09, 16'h8001);
      set_b(1, 6'h09, 16'h7FFF);
      cyc(); cyc();
      rst_n = 1'b0;
      #1;
      vectors++;
      if (b_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_ready: got %b expected 0000", b_ready);
      end
      vectors++;
      if ({b_es, b_eu, b_din} !== '0) begin
         errors++; $display("FAIL reset_ext: got %h expected 0", {b_es, b_eu, b_din});
      end
      vectors++;
      if ({b_rv, b_rid} !== '0) begin
         errors++; $display("FAIL reset_rsp: got %h expected 0", {b_rv, b_rid});
      end
      b_valid = '0;
      cyc();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cyc();
         vectors++;
         if (b_rv !== 1'b0) begin
            errors++; $display("FAIL post_reset_rsp: got %b expected 0 (cycle %0d)", b_rv, c);
         end
      end
      b_valid = 4'b0001;
      #1;
      vectors++;
      if (b_ready !== 4'b0001) begin
         errors++; $display("FAIL post_reset_busy0: got %b expected 0001", b_ready);
      end
      b_valid = 4'b0010;
      #1;
      vectors++;
      if (b_ready !== 4'b0010) begin
         errors++; $display("FAIL post_reset_busy1: got %b expected 0010", b_ready);
      end
      b_valid = '0;
      cyc();
   endtask

   task automatic test_single();
      set_a(1, 6'h09, 16'h8001);
      #1;
      vectors++;
      if (a_ready !== 4'b0010) begin
         errors++; $display("FAIL single_ready: got %b expected 0010", a_ready);
      end
      cyc();
      vectors++;
      if ({a_es, a_eu, a_din} !== {1'b1, 1'b0, 16'h8001}) begin
         errors++; $display("FAIL single_ext: got %b %b %h expected 1 0 8001", a_es, a_eu, a_din);
      end
      vectors++;
      if ({a_rv, a_rid, a_rd} !== {1'b1, 2'd1, 32'hFFFF8001}) begin
         errors++; $display("FAIL single_rsp: got %b %0d %h expected 1 1 ffff8001", a_rv, a_rid, a_rd);
      end
      vectors++;
      if (a_ready !== 4'b0000) begin
         errors++; $display("FAIL single_busy: got %b expected 0000", a_ready);
      end
      cyc();
      vectors++;
      if ({a_rv, a_ready} !== {1'b0, 4'b0010}) begin
         errors++; $display("FAIL single_release: got %b %b expected 0 0010", a_rv, a_ready);
      end
      a_valid = '0;
      cyc();
   endtask

   task automatic test_modes();
      logic [5:0]  ops  [4] = '{6'h0D, 6'h0F, 6'h0C, 6'h23};
      logic [15:0] imms [4] = '{16'h8001, 16'h1234, 16'hFFFF, 16'hFFF0};
      logic [31:0] exps [4] = '{32'h00008001, 32'h12340000, 32'h0000FFFF, 32'hFFFFFFF0};
      for (int i = 0; i < 4; i++) begin
         a_valid = '0;
         set_a(i, ops[i], imms[i]);
         cyc();
         vectors++;
         if ({a_rv, a_rid, a_rd} !== {1'b1, 2'(i), exps[i]}) begin
            errors++;
            $display("FAIL mode_%0d: got %b %0d %h expected 1 %0d %h", i, a_rv, a_rid, a_rd, i, exps[i]);
         end
      end
      a_valid = '0;
      cyc();
   endtask

   task automatic test_fairness();
      logic [3:0] g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) set_a(k, 6'h09, 16'(k));
      for (int c = 0; c < 5; c++) begin
         #1;
         vectors++;
         if (a_ready !== g[c]) begin
            errors++; $display("FAIL fair_grant_%0d: got %b expected %b", c, a_ready, g[c]);
         end
         cyc();
         vectors++;
         if ({a_rv, a_rid} !== {1'b1, 2'(c % 4)}) begin
            errors++; $display("FAIL fair_rsp_%0d: got %b %0d expected 1 %0d", c, a_rv, a_rid, c % 4);
         end
      end
      a_valid = '0;
      cyc(); cyc();
   endtask

   task automatic test_latency();
      b_valid = '0;
      set_b(0, 6'h08, 16'hFFFE);
      set_b(2, 6'h0E, 16'hFFFE);
      #1;
      vectors++;
      if (b_ready !== 4'b0001) begin
         errors++; $display("FAIL lat_grant0: got %b expected 0001", b_ready);
      end
      cyc();
      vectors++;
      if ({b_ready, b_rv} !== {4'b0100, 1'b0}) begin
         errors++; $display("FAIL lat_grant2: got %b %b expected 0100 0", b_ready, b_rv);
      end
      cyc();
      b_valid = '0;
      vectors++;
      if (b_rv !== 1'b0) begin
         errors++; $display("FAIL lat_early: got %b expected 0", b_rv);
      end
      cyc();
      vectors++;
      if ({b_rv, b_rid, b_rd} !== {1'b1, 2'd0, 32'hFFFFFFFE}) begin
         errors++; $display("FAIL lat_rsp0: got %b %0d %h expected 1 0 fffffffe", b_rv, b_rid, b_rd);
      end
      cyc();
      vectors++;
      if ({b_rv, b_rid, b_rd} !== {1'b1, 2'd2, 32'h0000FFFE}) begin
         errors++; $display("FAIL lat_rsp2: got %b %0d %h expected 1 2 0000fffe", b_rv, b_rid, b_rd);
      end
      cyc();
      vectors++;
      if (b_rv !== 1'b0) begin
         errors++; $display("FAIL lat_drain: got %b expected 0", b_rv);
      end
   endtask

   task automatic test_flush();
      b_valid = '0;
      set_b(0, 6'h23, 16'h9000);
      set_b(1, 6'h09, 16'h0001);
      set_b(2, 6'h0F, 16'h00AB);
      #1;
      vectors++;
      if (b_ready !== 4'b0001) begin
         errors++; $display("FAIL flush_first_grant: got %b expected 0001", b_ready);
      end
      cyc(); cyc(); cyc();
      flush = 1'b1;
      #1;
      vectors++;
      if ({b_rv, b_ready} !== {1'b0, 4'b0000}) begin
         errors++; $display("FAIL flush_cycle: got %b %b expected 0 0000", b_rv, b_ready);
      end
      cyc();
      flush = 1'b0;
      #1;
      vectors++;
      if ({b_rv, b_ready} !== {1'b0, 4'b0001}) begin
         errors++; $display("FAIL flush_after: got %b %b expected 0 0001", b_rv, b_ready);
      end
      b_valid = 4'b0001;
      cyc();
      b_valid = '0;
      for (int c = 0; c < 2; c++) begin
         vectors++;
         if (b_rv !== 1'b0) begin
            errors++; $display("FAIL flush_quiet_%0d: got %b expected 0", c, b_rv);
         end
         cyc();
      end
      vectors++;
      if ({b_rv, b_rid, b_rd} !== {1'b1, 2'd0, 32'hFFFF9000}) begin
         errors++; $display("FAIL flush_new_rsp: got %b %0d %h expected 1 0 ffff9000", b_rv, b_rid, b_rd);
      end
      cyc();
   endtask

   initial begin
      test_reset();
      test_single();
      test_modes();
      test_fairness();
      test_latency();
      test_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
